i2s_master_tx: RTL and testbench
================================

I2S_MASTER_TX -- requirements
Module: i2s_master_tx

Interface
REQ-001 SHALL provide parameter SCLK_DIV, default 32, clk cycles per I2S_sclk period (even, >=4).
REQ-002 SHALL have port clk input 1: 50 MHz system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-004 SHALL have port en input 1: high runs the serial link, low forces IDLE.
REQ-005 SHALL have port lft_in input 16: left sample, signed two's complement.
REQ-006 SHALL have port rght_in input 16: right sample, signed two's complement.
REQ-007 SHALL have port wrt input 1: one-clk strobe offering lft_in/rght_in.
REQ-008 SHALL have port rdy output 1: high when the holding register is empty.
REQ-009 SHALL have port I2S_sclk output 1: serial bit clock.
REQ-010 SHALL have port I2S_ws output 1: word select, 0 = left, 1 = right.
REQ-011 SHALL have port I2S_data output 1: serial data, MSB first.
REQ-012 SHALL have port frm_strt output 1: one-clk pulse at frame load.
REQ-013 SHALL have port underrun output 1: one-clk pulse when a frame loads with no new sample.

Function
REQ-014 SHALL implement states IDLE and RUN: IDLE->RUN on en=1; RUN->IDLE on en=0 in any cycle, including mid-frame.
REQ-015 SHALL, in RUN, count a divider 0..SCLK_DIV/2-1, toggle I2S_sclk at terminal count, and wrap the divider to 0.
REQ-016 SHALL define a rise event as a toggle while sclk=0 and a fall event as a toggle while sclk=1.
REQ-017 SHALL make the first rise event SCLK_DIV/2 clks after RUN entry and the first fall event (k=0) SCLK_DIV clks after RUN entry.
REQ-018 SHALL keep a 6-bit frame bit index k, advanced on every fall event and wrapping 63->0.
REQ-019 SHALL update I2S_ws and I2S_data only on fall events, so the receiver samples on rise.
REQ-020 SHALL drive I2S_ws to 0 for k=0..31 and to 1 for k=32..63.
REQ-021 SHALL, at k=0, load a 64-bit shifter with {0, lft[15:0], 16 zeros, rght[15:0], 15 zeros} and shift one bit per fall event.
REQ-022 SHALL therefore place each channel MSB one sclk after its ws transition (I2S standard), with left at k=1..16 and right at k=33..48.
REQ-023 SHALL use a single holding register with a full flag, where rdy = !full.
REQ-024 SHALL load the holding register and set full when wrt=1 and rdy=1.
REQ-025 SHALL ignore wrt when rdy=0.
REQ-026 SHALL, at the k=0 load, copy the holding register to the shifter, clear full, and pulse frm_strt.
REQ-027 SHALL, at a k=0 load with full=0, pulse underrun and fill data per REQ-033/034.
REQ-028 SHALL treat wrt coinciding with a k=0 load while full=0 as an underrun for that frame; the sample is then accepted and full is set for the next frame.
REQ-029 SHALL treat wrt coinciding with a k=0 load while full=1 as ignored (rdy=0 that cycle).
REQ-030 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-031 SHALL, on rst_n=0, set: state IDLE, I2S_sclk=0, I2S_ws=1, I2S_data=0, rdy=1, frm_strt=0, underrun=0, counters 0, holding register 0, shifter 0.
REQ-032 SHALL, on entering IDLE via en=0, apply the reset values to sclk, ws, data, divider, k and shifter; the holding register and full flag are retained.

Configuration
REQ-033 SHALL, when macro I2S_TX_MUTE_ON_UNDERRUN_EN is defined, load all-zero samples on an underrun frame.
REQ-034 SHALL, when I2S_TX_MUTE_ON_UNDERRUN_EN is undefined, reload the last holding-register contents (repeat previous sample) on an underrun frame.

Verification
REQ-035 SHALL verify timing: SCLK_DIV=32, en=1 -> sclk period 640 ns, ws period 64 sclk (40.96 us); first ws fall 32 clks after en.
REQ-036 SHALL verify serialization: write lft=16'hA55A, rght=16'h8001 before k=0 -> data at k=1..16 = A55A MSB first, k=33..48 = 8001, all other bits 0; an i2s_slave loopback recovers both words.
REQ-037 SHALL verify handshake: wrt with rdy=1 -> rdy=0 next clk; second wrt is ignored; rdy=1 again the clk after the k=0 load.
REQ-038 SHALL verify underrun: no wrt for a frame -> underrun pulses 1 clk at k=0 and a frame of zeros is sent (macro defined) or the previous samples are repeated (macro undefined).
REQ-039 SHALL verify IDLE entry: en=0 at k=40 -> next clk sclk=0, ws=1, data=0; en=1 restarts with k=0 after 32 clks and the held sample is transmitted.
REQ-040 SHALL verify reset: rst_n low mid-frame -> all outputs at REQ-031 values asynchronously, and a following wrt is accepted.

Source files
------------

// File: rtl/i2s_master_tx.sv
// ==== i2s_master_tx : 16-bit stereo I2S master transmitter, 64 sclk per frame ==== Rev 1.0
// Optional build macro I2S_TX_MUTE_ON_UNDERRUN_EN: send silence instead of repeating the last sample on underrun.
`default_nettype none
`timescale 1ns/1ps

module i2s_master_tx #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] lft_in,
  input  logic [15:0] rght_in,
  input  logic        wrt,
  output logic        rdy,
  output logic        I2S_sclk,
  output logic        I2S_ws,
  output logic        I2S_data,
  output logic        frm_strt,
  output logic        underrun
);

  localparam int                 c_HALF    = SCLK_DIV / 2;
  localparam int                 c_DIV_W   = (c_HALF > 1) ? $clog2(c_HALF) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_TC  = c_DIV_W'(c_HALF - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE = c_DIV_W'(1);
  localparam logic [0:0]         c_ST_IDLE = 1'b0;
  localparam logic [0:0]         c_ST_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [c_DIV_W-1:0] r_div;
  logic [5:0]         r_k;
  logic [63:0]        r_shift;
  logic [15:0]        r_hold_l;
  logic [15:0]        r_hold_r;
  logic               r_empty;
  logic               r_sclk;
  logic               r_ws;
  logic               r_data;
  logic               r_frm_strt;
  logic               r_underrun;

  logic               w_run;
  logic               w_tc;
  logic               w_fall;
  logic               w_load;
  logic [15:0]        w_src_l;
  logic [15:0]        w_src_r;
  logic [63:0]        w_frame;

  assign w_run  = (r_state == c_ST_RUN) && en;
  assign w_tc   = (r_div == c_DIV_TC);
  assign w_fall = w_run && w_tc && r_sclk;
  assign w_load = w_fall && (r_k == 6'd0);

`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
  assign w_src_l = r_empty ? 16'h0000 : r_hold_l;
  assign w_src_r = r_empty ? 16'h0000 : r_hold_r;
`else
  // On underrun the holding register still has the previous sample, so it simply repeats.
  assign w_src_l = r_hold_l;
  assign w_src_r = r_hold_r;
`endif

  // One leading pad bit puts each channel MSB one sclk after its ws edge.
  assign w_frame = {1'b0, w_src_l, 16'h0000, w_src_r, 15'h0000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_div      <= '0;
      r_k        <= 6'd0;
      r_shift    <= 64'd0;
      r_sclk     <= 1'b0;
      r_ws       <= 1'b1;
      r_data     <= 1'b0;
      r_frm_strt <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_frm_strt <= w_load;
      r_underrun <= w_load && r_empty;
      if (r_state == c_ST_RUN && !en) begin
        r_state <= c_ST_IDLE;
        r_div   <= '0;
        r_k     <= 6'd0;
        r_shift <= 64'd0;
        r_sclk  <= 1'b0;
        r_ws    <= 1'b1;
        r_data  <= 1'b0;
      end else if (r_state == c_ST_IDLE) begin
        if (en) begin
          r_state <= c_ST_RUN;
        end
      end else begin
        if (w_tc) begin
          r_div  <= '0;
          r_sclk <= ~r_sclk;
        end else begin
          r_div  <= r_div + c_DIV_ONE;
        end
        if (w_fall) begin
          r_k  <= r_k + 6'd1;
          r_ws <= r_k[5];
          if (w_load) begin
            r_data  <= w_frame[63];
            r_shift <= {w_frame[62:0], 1'b0};
          end else begin
            r_data  <= r_shift[63];
            r_shift <= {r_shift[62:0], 1'b0};
          end
        end
      end
    end
  end

  // A frame load frees the slot in the same cycle, so a coincident wrt sees rdy=0 and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_l <= 16'h0000;
      r_hold_r <= 16'h0000;
      r_empty  <= 1'b1;
    end else if (w_load && !r_empty) begin
      r_empty  <= 1'b1;
    end else if (wrt && r_empty) begin
      r_hold_l <= lft_in;
      r_hold_r <= rght_in;
      r_empty  <= 1'b0;
    end
  end

  assign rdy      = r_empty;
  assign I2S_sclk = r_sclk;
  assign I2S_ws   = r_ws;
  assign I2S_data = r_data;
  assign frm_strt = r_frm_strt;
  assign underrun = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_master_tx.sv
// ==== tb_i2s_master_tx : directed bench for i2s_master_tx (timing, serialization, handshake, underrun, idle, reset) ==== Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_i2s_master_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        wrt = 1'b0;
  logic [15:0] lft_in = 16'h0000;
  logic [15:0] rght_in = 16'h0000;
  logic        rdy;
  logic        sclk;
  logic        ws;
  logic        data;
  logic        frm_strt;
  logic        underrun;

  int n_chk = 0;
  int n_bad = 0;

  i2s_master_tx #(.SCLK_DIV(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .lft_in   (lft_in),
    .rght_in  (rght_in),
    .wrt      (wrt),
    .rdy      (rdy),
    .I2S_sclk (sclk),
    .I2S_ws   (ws),
    .I2S_data (data),
    .frm_strt (frm_strt),
    .underrun (underrun)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] frame(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 16'h0000, r, 15'h0000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] l, input logic [15:0] r);
    lft_in  = l;
    rght_in = r;
    wrt     = 1'b1;
    tick();
    wrt     = 1'b0;
  endtask

  task automatic wait_rise(output int n);
    logic p;
    bit   ok;
    n  = 0;
    ok = 1'b0;
    p  = sclk;
    while (!ok && n < 200) begin
      tick();
      n++;
      if (!p && sclk) ok = 1'b1;
      p = sclk;
    end
    if (!ok) check("rise_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_frm(output int n);
    n = 0;
    while (frm_strt !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (frm_strt !== 1'b1) check("frm_timeout", 64'(frm_strt), 64'd1);
  endtask

  task automatic wait_ws_low(output int n);
    n = 0;
    while (ws !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Receiver side: sample data/ws on each sclk rise.
  task automatic capture(input int nbits, output logic [63:0] d, output logic [63:0] w,
                         output int last, output int total);
    int n;
    d = 64'd0;
    w = 64'd0;
    last = 0;
    total = 0;
    for (int i = 0; i < nbits; i++) begin
      wait_rise(n);
      total += n;
      last = n;
      d = {d[62:0], data};
      w = {w[62:0], ws};
    end
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] w;
    logic [63:0] exp_d;
    int          last;
    int          tot;
    int          n;

    repeat (2) tick();
    check("reset_outs", 64'({sclk, ws, data, rdy, frm_strt, underrun}), 64'b010100);
    rst_n = 1'b1;
    tick();

    wr(16'hA55A, 16'h8001);
    check("rdy_after_wrt", 64'(rdy), 64'd0);
    wr(16'h1111, 16'h2222);
    check("rdy_2nd_wrt", 64'(rdy), 64'd0);

    en = 1'b1;
    tick();
    wait_ws_low(n);
    check("first_ws_fall", 64'(n), 64'd32);
    check("frm_strt_f1", 64'(frm_strt), 64'd1);
    check("no_underrun_f1", 64'(underrun), 64'd0);
    check("rdy_after_load", 64'(rdy), 64'd1);

    capture(64, d, w, last, tot);
    check("frame1_data", d, frame(16'hA55A, 16'h8001));
    check("frame1_ws", w, 64'h00000000_FFFFFFFF);
    check("sclk_period", 64'(last), 64'd32);
    wait_frm(n);
    check("ws_period", 64'(tot + n), 64'd2048);
    check("underrun_f2", 64'(underrun), 64'd1);
    tick();
    check("underrun_1clk", 64'({frm_strt, underrun}), 64'd0);

    wr(16'hC3C3, 16'h7FFE);
    check("rdy_wrt_f2", 64'(rdy), 64'd0);
    capture(64, d, w, last, tot);
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
    exp_d = 64'd0;
`else
    exp_d = frame(16'hA55A, 16'h8001);
`endif
    check("frame2_underrun", d, exp_d);

    // wrt on the load cycle while full is dropped
    repeat (15) tick();
    wr(16'h1111, 16'h2222);
    check("f3_load", 64'({frm_strt, underrun, rdy}), 64'b101);
    capture(64, d, w, last, tot);
    check("frame3_data", d, frame(16'hC3C3, 16'h7FFE));

    // wrt on the load cycle while empty: underrun frame, sample kept for next frame
    repeat (15) tick();
    wr(16'h1234, 16'hFFFF);
    check("f4_load", 64'({frm_strt, underrun, rdy}), 64'b110);
    capture(64, d, w, last, tot);
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
    exp_d = 64'd0;
`else
    exp_d = frame(16'hC3C3, 16'h7FFE);
`endif
    check("frame4_underrun", d, exp_d);

    wait_frm(n);
    check("f5_gap", 64'(n), 64'd16);
    check("f5_load", 64'({underrun, rdy}), 64'b01);
    capture(41, d, w, last, tot);
    exp_d = frame(16'h1234, 16'hFFFF);
    check("frame5_k0_40", d, exp_d >> 23);

    en = 1'b0;
    tick();
    check("idle_outs", 64'({sclk, ws, data}), 64'b010);
    wr(16'hABCD, 16'h0F0F);
    check("rdy_idle_wrt", 64'(rdy), 64'd0);
    repeat (40) tick();
    check("idle_quiet", 64'({sclk, ws, data, frm_strt}), 64'b0100);

    en = 1'b1;
    tick();
    wait_ws_low(n);
    check("restart_ws_fall", 64'(n), 64'd32);
    check("restart_load", 64'({frm_strt, underrun, rdy}), 64'b101);
    capture(64, d, w, last, tot);
    check("restart_frame", d, frame(16'hABCD, 16'h0F0F));
    check("restart_ws", w, 64'h00000000_FFFFFFFF);

    wait_frm(n);
    capture(5, d, w, last, tot);
    wr(16'h5A5A, 16'hA5A5);
    check("rdy_pre_reset", 64'({rdy, sclk, ws}), 64'b010);
    #4;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'({sclk, ws, data, rdy, frm_strt, underrun}), 64'b010100);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wr(16'h7777, 16'h8888);
    check("wrt_after_reset", 64'(rdy), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
